// File: rtl/apu_mixer_n_if.sv
// Bundle of mixer control, sample inputs and audio outputs shared between
// the tone-generator side (master) and the mixer (slave).
interface apu_mixer_n_if #(
    parameter int CHANNELS   = 4,
    parameter int IN_WIDTH   = 4,
    parameter int GAIN_WIDTH = 4,
    parameter int OUT_WIDTH  = 8
);
    logic                            sample_en;
    logic [CHANNELS*IN_WIDTH-1:0]    ch_data;
    logic [CHANNELS*GAIN_WIDTH-1:0]  ch_gain;
    logic [CHANNELS-1:0]             ch_mute;
    logic [OUT_WIDTH-1:0]            mix;
    logic                            mix_valid;
    logic                            clip;
    logic                            overrun;
    logic                            busy;
    logic [3:0]                      dac;
    logic                            pwm;

    modport master (
        output sample_en, ch_data, ch_gain, ch_mute,
        input  mix, mix_valid, clip, overrun, busy, dac, pwm
    );

    modport slave (
        input  sample_en, ch_data, ch_gain, ch_mute,
        output mix, mix_valid, clip, overrun, busy, dac, pwm
    );
endinterface

// File: rtl/apu_mixer_n.sv
// N-channel time-multiplexed audio mixer: one gain multiply per clk into an
// accumulator, shift + saturate, then a PWM or sigma-delta 1-bit modulator.
module apu_mixer_n #(
    parameter int CHANNELS   = 4,
    parameter int IN_WIDTH   = 4,
    parameter int GAIN_WIDTH = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 2,
    parameter int MODE       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    apu_mixer_n_if.slave  bus
);
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = IN_WIDTH + GAIN_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(CHANNELS + 1);
    localparam int EXT_W  = ACC_W + OUT_WIDTH;
    localparam logic [EXT_W-1:0] MAX_MIX = {{ACC_W{1'b0}}, {OUT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                          state_reg;
    logic [CHANNELS*IN_WIDTH-1:0]    snap_data_reg;
    logic [CHANNELS*GAIN_WIDTH-1:0]  snap_gain_reg;
    logic [CHANNELS-1:0]             snap_mute_reg;
    logic [ACC_W-1:0]                acc_reg;
    logic [IDX_W-1:0]                idx_reg;
    logic [OUT_WIDTH-1:0]            mix_reg;
    logic                            mix_valid_reg;
    logic                            clip_reg;
    logic                            overrun_reg;
    logic                            busy_reg;

    logic [IN_WIDTH-1:0]   data_arr [CHANNELS];
    logic [GAIN_WIDTH-1:0] gain_arr [CHANNELS];
    logic [PROD_W-1:0]     prod;
    logic [EXT_W-1:0]      ext_sum;
    logic                  start;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_unpack
        assign data_arr[gi] = snap_data_reg[gi*IN_WIDTH +: IN_WIDTH];
        assign gain_arr[gi] = snap_gain_reg[gi*GAIN_WIDTH +: GAIN_WIDTH];
    end

    // Single shared multiplier, walked across channels by idx_reg.
    assign prod = snap_mute_reg[idx_reg] ? '0
                : PROD_W'(data_arr[idx_reg]) * PROD_W'(gain_arr[idx_reg]);

    assign ext_sum = {{OUT_WIDTH{1'b0}}, acc_reg} >> SHIFT;

    // DONE can take a new frame in the same cycle it publishes the result.
    assign start = bus.sample_en && (state_reg != ACCUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            snap_data_reg <= '0;
            snap_gain_reg <= '0;
            snap_mute_reg <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
            mix_reg       <= '0;
            mix_valid_reg <= 1'b0;
            clip_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            mix_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            case (state_reg)
                IDLE: ;
                ACCUM: begin
                    acc_reg     <= acc_reg + ACC_W'(prod);
                    idx_reg     <= idx_reg + IDX_W'(1);
                    overrun_reg <= bus.sample_en;
                    if (idx_reg == IDX_W'(CHANNELS - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    if (ext_sum > MAX_MIX) begin
                        mix_reg  <= '1;
                        clip_reg <= 1'b1;
                    end else begin
                        mix_reg  <= ext_sum[OUT_WIDTH-1:0];
                        clip_reg <= 1'b0;
                    end
                    mix_valid_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
            if (start) begin
                snap_data_reg <= bus.ch_data;
                snap_gain_reg <= bus.ch_gain;
                snap_mute_reg <= bus.ch_mute;
                acc_reg       <= '0;
                idx_reg       <= '0;
                busy_reg      <= 1'b1;
                state_reg     <= ACCUM;
            end
        end
    end

    if (MODE == 0) begin : gen_pwm
        logic [OUT_WIDTH-1:0] pc_reg;
        logic [OUT_WIDTH-1:0] hold_reg;
        logic                 pwm_reg;
        // Duty only changes at the period boundary to avoid mid-period glitches.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pc_reg   <= '0;
                hold_reg <= '0;
                pwm_reg  <= 1'b0;
            end else begin
                pc_reg  <= pc_reg + OUT_WIDTH'(1);
                pwm_reg <= (pc_reg < hold_reg);
                if (pc_reg == '1)
                    hold_reg <= mix_reg;
            end
        end
        assign bus.pwm = pwm_reg;
    end else begin : gen_sd
        logic [OUT_WIDTH:0]   sd_reg;
        logic [OUT_WIDTH-1:0] hold_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sd_reg   <= '0;
                hold_reg <= '0;
            end else begin
                sd_reg <= {1'b0, sd_reg[OUT_WIDTH-1:0]} + {1'b0, hold_reg};
                if (mix_valid_reg)
                    hold_reg <= mix_reg;
            end
        end
        assign bus.pwm = sd_reg[OUT_WIDTH];
    end

    assign bus.mix       = mix_reg;
    assign bus.mix_valid = mix_valid_reg;
    assign bus.clip      = clip_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.busy      = busy_reg;
    assign bus.dac       = mix_reg[OUT_WIDTH-1 -: 4];
endmodule

// File: tb/tb_apu_mixer_n.sv
// Directed bench: two mixers (SHIFT=2/PWM and SHIFT=0/sigma-delta) fed the same frames.
module tb_apu_mixer_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [15:0] ch_data;
    logic [15:0] ch_gain;
    logic [3:0]  ch_mute;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apu_mixer_n_if #(.CHANNELS(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .OUT_WIDTH(8)) bus0 ();
    apu_mixer_n_if #(.CHANNELS(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .OUT_WIDTH(8)) bus1 ();

    assign bus0.sample_en = sample_en;
    assign bus0.ch_data   = ch_data;
    assign bus0.ch_gain   = ch_gain;
    assign bus0.ch_mute   = ch_mute;
    assign bus1.sample_en = sample_en;
    assign bus1.ch_data   = ch_data;
    assign bus1.ch_gain   = ch_gain;
    assign bus1.ch_mute   = ch_mute;

    apu_mixer_n #(.CHANNELS(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .OUT_WIDTH(8),
                  .SHIFT(2), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    apu_mixer_n #(.CHANNELS(4), .IN_WIDTH(4), .GAIN_WIDTH(4), .OUT_WIDTH(8),
                  .SHIFT(0), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one frame, scramble inputs during ACCUM, wait (bounded) for mix_valid.
    task automatic run_frame(input logic [15:0] d, input logic [15:0] g,
                             input logic [3:0] m, output int lat);
        ch_data = d; ch_gain = g; ch_mute = m; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        ch_data = 16'hFFFF; ch_gain = 16'hFFFF; ch_mute = 4'b0000;
        lat = 0;
        while (bus0.mix_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        $display("frame data=%h gain=%h mute=%b lat=%0d mix0=%0d clip0=%0d mix1=%0d clip1=%0d",
                 d, g, m, lat, bus0.mix, bus0.clip, bus1.mix, bus1.clip);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_en = 1'b0; ch_data = '0; ch_gain = '0; ch_mute = '0;
        repeat (3) tick();
        checks++;
        if ({bus0.mix, bus0.mix_valid, bus0.clip, bus0.overrun, bus0.busy, bus0.pwm} !== 13'd0) begin
            failures++;
            $display("FAIL reset_dut0 got=%b want=0", {bus0.mix, bus0.mix_valid, bus0.clip, bus0.overrun, bus0.busy, bus0.pwm});
        end
        checks++;
        if ({bus1.mix, bus1.mix_valid, bus1.clip, bus1.overrun, bus1.busy, bus1.pwm} !== 13'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b want=0", {bus1.mix, bus1.mix_valid, bus1.clip, bus1.overrun, bus1.busy, bus1.pwm});
        end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_single();
        int lat;
        run_frame(16'h000F, 16'h555F, 4'b0000, lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL single_latency got=%0d want=5", lat); end
        checks++;
        if (bus0.mix !== 8'd56) begin failures++; $display("FAIL single_mix got=%0d want=56", bus0.mix); end
        checks++;
        if (bus0.clip !== 1'b0) begin failures++; $display("FAIL single_clip got=%b want=0", bus0.clip); end
        checks++;
        if (bus0.dac !== 4'd3) begin failures++; $display("FAIL single_dac got=%0d want=3", bus0.dac); end
        checks++;
        if (bus1.mix !== 8'd225) begin failures++; $display("FAIL single_mix_shift0 got=%0d want=225", bus1.mix); end
        tick();
        checks++;
        if (bus0.mix_valid !== 1'b0 || bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got=valid%b busy%b want=valid0 busy0", bus0.mix_valid, bus0.busy);
        end
    endtask

    task automatic test_saturation();
        int lat;
        run_frame(16'hFFFF, 16'hFFFF, 4'b0000, lat);
        checks++;
        if (bus0.mix !== 8'd225 || bus0.clip !== 1'b0) begin
            failures++; $display("FAIL sat_shift2 got=%0d/%b want=225/0", bus0.mix, bus0.clip);
        end
        checks++;
        if (bus1.mix !== 8'd255 || bus1.clip !== 1'b1) begin
            failures++; $display("FAIL sat_shift0 got=%0d/%b want=255/1", bus1.mix, bus1.clip);
        end
        checks++;
        if (bus1.dac !== 4'd15) begin failures++; $display("FAIL sat_dac got=%0d want=15", bus1.dac); end
        tick();
    endtask

    task automatic test_mute();
        int lat;
        run_frame(16'h8888, 16'hFFFF, 4'b0101, lat);
        checks++;
        if (bus1.mix !== 8'd240 || bus1.clip !== 1'b0) begin
            failures++; $display("FAIL mute_shift0 got=%0d/%b want=240/0", bus1.mix, bus1.clip);
        end
        checks++;
        if (bus0.mix !== 8'd60) begin failures++; $display("FAIL mute_shift2 got=%0d want=60", bus0.mix); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int valids;
        ch_data = 16'hFFFF; ch_gain = 16'hFFFF; ch_mute = '0; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus1.mix !== 8'd0 || bus0.busy !== 1'b0 || bus0.mix_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear got=mix%0d busy%b valid%b want=0", bus1.mix, bus0.busy, bus0.mix_valid);
        end
        rst_n = 1'b1;
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus0.mix_valid === 1'b1) valids++;
        end
        checks++;
        if (valids !== 0) begin failures++; $display("FAIL midreset_novalid got=%0d want=0", valids); end
        run_frame(16'h000F, 16'h555F, 4'b0000, lat);
        checks++;
        if (lat !== 5 || bus0.mix !== 8'd56) begin
            failures++; $display("FAIL midreset_recover got=lat%0d mix%0d want=lat5 mix56", lat, bus0.mix);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        ch_data = 16'h000F; ch_gain = 16'hFFFF; ch_mute = '0; sample_en = 1'b1;
        tick();                                  // edge t
        sample_en = 1'b0; ch_data = 16'hFFFF;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.overrun !== 1'b0) begin
            failures++; $display("FAIL b2b_busy got=busy%b ovr%b want=busy1 ovr0", bus0.busy, bus0.overrun);
        end
        tick();                                  // t+1
        sample_en = 1'b1;
        tick();                                  // t+2
        checks++;
        if (bus0.overrun !== 1'b1 || bus1.overrun !== 1'b1) begin
            failures++; $display("FAIL b2b_overrun got=%b%b want=11", bus0.overrun, bus1.overrun);
        end
        sample_en = 1'b0;
        tick();                                  // t+3
        checks++;
        if (bus0.overrun !== 1'b0 || bus0.mix_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_pulse got=ovr%b valid%b want=0 0", bus0.overrun, bus0.mix_valid);
        end
        tick();                                  // t+4
        checks++;
        if (bus0.mix_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b want=0", bus0.mix_valid); end
        ch_data = 16'h8888; ch_gain = 16'h8888; sample_en = 1'b1;
        tick();                                  // t+5
        $display("b2b first frame valid=%b mix0=%0d ovr=%b", bus0.mix_valid, bus0.mix, bus0.overrun);
        checks++;
        if (bus0.mix_valid !== 1'b1 || bus0.mix !== 8'd56) begin
            failures++; $display("FAIL b2b_first got=valid%b mix%0d want=valid1 mix56", bus0.mix_valid, bus0.mix);
        end
        checks++;
        if (bus0.overrun !== 1'b0) begin failures++; $display("FAIL b2b_accept_ovr got=%b want=0", bus0.overrun); end
        sample_en = 1'b0; ch_data = '0;
        lat = 0;
        tick();
        lat++;
        while (bus0.mix_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        $display("b2b second frame lat=%0d mix0=%0d mix1=%0d clip1=%b", lat, bus0.mix, bus1.mix, bus1.clip);
        checks++;
        if (lat !== 5 || bus0.mix !== 8'd64) begin
            failures++; $display("FAIL b2b_second got=lat%0d mix%0d want=lat5 mix64", lat, bus0.mix);
        end
        checks++;
        if (bus1.mix !== 8'd255 || bus1.clip !== 1'b1) begin
            failures++; $display("FAIL b2b_second_sat got=%0d/%b want=255/1", bus1.mix, bus1.clip);
        end
        tick();
    endtask

    task automatic test_modulator();
        int lat;
        int bad;
        int highs;
        logic prev;
        run_frame(16'h0088, 16'h0088, 4'b0000, lat);
        checks++;
        if (bus1.mix !== 8'd128) begin failures++; $display("FAIL sd_mix got=%0d want=128", bus1.mix); end
        repeat (3) tick();
        prev = bus1.pwm;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus1.pwm === prev) bad++;
            prev = bus1.pwm;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL sd_toggle got=%0d non-toggles want=0", bad); end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (bus1.pwm === 1'b1) highs++;
        end
        $display("sigma-delta mix=128 highs=%0d/256", highs);
        checks++;
        if (highs !== 128) begin failures++; $display("FAIL sd_density got=%0d want=128", highs); end

        run_frame(16'h8888, 16'h8888, 4'b0000, lat);
        checks++;
        if (bus0.mix !== 8'd64) begin failures++; $display("FAIL pwm_mix got=%0d want=64", bus0.mix); end
        repeat (300) tick();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (bus0.pwm === 1'b1) highs++;
        end
        $display("pwm mix=64 highs=%0d/256", highs);
        checks++;
        if (highs !== 64) begin failures++; $display("FAIL pwm_density got=%0d want=64", highs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_mute();
        test_reset_mid();
        test_back_to_back();
        test_modulator();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
